// File: rtl/triangle_pkg.sv
// rtl/triangle_pkg.sv - shared state, shape-kind and width definitions for the triangle sequencer
package triangle_pkg;

  localparam int SIDE_W = 8;

  typedef enum logic [1:0] {
    LD_A = 2'd0,
    LD_B = 2'd1,
    LD_C = 2'd2,
    HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    KIND_NONE        = 2'd0,
    KIND_SCALENE     = 2'd1,
    KIND_ISOSCELES   = 2'd2,
    KIND_EQUILATERAL = 2'd3
  } kind_t;

endpackage

// File: rtl/triangle_seq_if.sv
// rtl/triangle_seq_if.sv - byte input and result output channels of the triangle sequencer
interface triangle_seq_if;
  import triangle_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [SIDE_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_tri;
  kind_t             out_kind;
  logic [SIDE_W-1:0] out_a;
  logic [SIDE_W-1:0] out_b;
  logic [SIDE_W-1:0] out_c;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_tri, out_kind, out_a, out_b, out_c
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_tri, out_kind, out_a, out_b, out_c
  );

endinterface

// File: rtl/triangle_chk.sv
// rtl/triangle_chk.sv - combinational triangle test and shape classification of one triplet
module triangle_chk
  import triangle_pkg::*;
(
  input  logic [SIDE_W-1:0] a,
  input  logic [SIDE_W-1:0] b,
  input  logic [SIDE_W-1:0] c,
  output logic              is_tri,
  output kind_t             kind
);

  // One extra bit keeps 255 + 255 from wrapping.
  logic [SIDE_W:0] sum_ab;
  logic [SIDE_W:0] sum_ac;
  logic [SIDE_W:0] sum_bc;

  assign sum_ab = {1'b0, a} + {1'b0, b};
  assign sum_ac = {1'b0, a} + {1'b0, c};
  assign sum_bc = {1'b0, b} + {1'b0, c};

  always_comb begin
    is_tri = (sum_ab > {1'b0, c}) && (sum_ac > {1'b0, b}) && (sum_bc > {1'b0, a});
    kind   = KIND_NONE;
    if (is_tri) begin
      if ((a == b) && (b == c)) begin
        kind = KIND_EQUILATERAL;
      end else if ((a == b) || (a == c) || (b == c)) begin
        kind = KIND_ISOSCELES;
      end else begin
        kind = KIND_SCALENE;
      end
    end
  end

endmodule

// File: rtl/triangle_seq.sv
// rtl/triangle_seq.sv - byte-serial triplet assembler with registered result channel and saturating counters
module triangle_seq
  import triangle_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  triangle_seq_if.slave    bus,
  output logic [CNT_W-1:0] cnt_all,
  output logic [CNT_W-1:0] cnt_tri
);

  state_t            state;
  logic [SIDE_W-1:0] a_q;
  logic [SIDE_W-1:0] b_q;
  logic              chk_tri;
  kind_t             chk_kind;
  logic              out_valid;
  logic              out_tri;
  kind_t             out_kind;
  logic [SIDE_W-1:0] out_a;
  logic [SIDE_W-1:0] out_b;
  logic [SIDE_W-1:0] out_c;
  logic              in_ready;

  // The third side is checked straight off the input bus so the result lands with C.
  triangle_chk u_chk (
    .a      (a_q),
    .b      (b_q),
    .c      (bus.in_data),
    .is_tri (chk_tri),
    .kind   (chk_kind)
  );

  assign in_ready      = rst_n && !clr && (state != HOLD);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_tri   = out_tri;
  assign bus.out_kind  = out_kind;
  assign bus.out_a     = out_a;
  assign bus.out_b     = out_b;
  assign bus.out_c     = out_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LD_A;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      out_tri   <= 1'b0;
      out_kind  <= KIND_NONE;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      cnt_all   <= '0;
      cnt_tri   <= '0;
    end else if (clr) begin
      state     <= LD_A;
      a_q       <= '0;
      b_q       <= '0;
      out_valid <= 1'b0;
      out_tri   <= 1'b0;
      out_kind  <= KIND_NONE;
      out_a     <= '0;
      out_b     <= '0;
      out_c     <= '0;
      cnt_all   <= '0;
      cnt_tri   <= '0;
    end else begin
      case (state)
        LD_A: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_data;
            state <= LD_B;
          end
        end
        LD_B: begin
          if (bus.in_valid) begin
            b_q   <= bus.in_data;
            state <= LD_C;
          end
        end
        LD_C: begin
          if (bus.in_valid) begin
            out_a     <= a_q;
            out_b     <= b_q;
            out_c     <= bus.in_data;
            out_tri   <= chk_tri;
            out_kind  <= chk_kind;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= LD_A;
            if (cnt_all != {CNT_W{1'b1}}) begin
              cnt_all <= cnt_all + CNT_W'(1);
            end
            if (out_tri && (cnt_tri != {CNT_W{1'b1}})) begin
              cnt_tri <= cnt_tri + CNT_W'(1);
            end
          end
        end
        default: state <= LD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_seq.sv
// tb/tb_triangle_seq.sv - self-checking bench for triangle_seq with a 16-bit and a 2-bit counter instance
module tb_triangle_seq;
  import triangle_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [15:0] cnt_all1;
  logic [15:0] cnt_tri1;
  logic [1:0]  cnt_all2;
  logic [1:0]  cnt_tri2;

  int checks = 0;
  int errors = 0;
  int m_all  = 0;
  int m_tri  = 0;

  always #5 clk = ~clk;

  triangle_seq_if bus1 ();
  triangle_seq_if bus2 ();

  // The narrow-counter instance sees exactly the same stream as the main one.
  assign bus2.in_valid  = bus1.in_valid;
  assign bus2.in_data   = bus1.in_data;
  assign bus2.out_ready = bus1.out_ready;

  triangle_seq #(.CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus1.slave),
    .cnt_all (cnt_all1),
    .cnt_tri (cnt_tri1)
  );

  triangle_seq #(.CNT_W(2)) dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus2.slave),
    .cnt_all (cnt_all2),
    .cnt_tri (cnt_tri2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model(input int a, input int b, input int c, output bit t, output int k);
    t = (a + b > c) && (a + c > b) && (b + c > a);
    if (!t)                           k = 0;
    else if (a == b && b == c)        k = 3;
    else if (a == b || b == c || a == c) k = 2;
    else                              k = 1;
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic count_check(input string tag);
    check({tag, "_all"},     cnt_all1, m_all);
    check({tag, "_tri"},     cnt_tri1, m_tri);
    check({tag, "_sat_all"}, cnt_all2, sat3(m_all));
    check({tag, "_sat_tri"}, cnt_tri2, sat3(m_tri));
  endtask

  task automatic push(input logic [7:0] d, input int gap);
    bit rdy;
    bus1.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    rdy = 1'b0;
    for (int n = 0; n < 20 && !rdy; n++) begin
      @(negedge clk);
      rdy = bus1.in_ready;
      @(posedge clk); #1;
    end
    check("push_accept", rdy, 1);
    bus1.in_valid = 1'b0;
  endtask

  task automatic run_tri(input int a, input int b, input int c,
                         input int g0, input int g1, input int g2, input int stall);
    bit t;
    int k;
    model(a, b, c, t, k);
    push(a[7:0], g0);
    push(b[7:0], g1);
    push(c[7:0], g2);
    check("lat_valid", bus1.out_valid, 1);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      check("hold_valid", bus1.out_valid, 1);
      check("hold_ready", bus1.in_ready, 0);
      check("out_tri",    bus1.out_tri, t);
      check("out_kind",   bus1.out_kind, k);
      check("out_a",      bus1.out_a, a);
      check("out_b",      bus1.out_b, b);
      check("out_c",      bus1.out_c, c);
      count_check("hold");
      if (i == stall) bus1.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus1.out_ready = 1'b0;
    m_all++;
    if (t) m_tri++;
    @(negedge clk);
    check("done_valid", bus1.out_valid, 0);
    check("done_ready", bus1.in_ready, 1);
    count_check("done");
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'd9;
    @(negedge clk);
    check("clr_ready", bus1.in_ready, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    m_all = 0;
    m_tri = 0;
    @(negedge clk);
    check("clr_valid", bus1.out_valid, 0);
    check("clr_ready_after", bus1.in_ready, 1);
    count_check("clr");
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, bus1.out_valid, 0);
    check({tag, "_tri"},   bus1.out_tri, 0);
    check({tag, "_kind"},  bus1.out_kind, 0);
    check({tag, "_a"},     bus1.out_a, 0);
    check({tag, "_b"},     bus1.out_b, 0);
    check({tag, "_c"},     bus1.out_c, 0);
    count_check(tag);
  endtask

  initial begin
    int ra, rb, rc;
    rst_n = 1'b0;
    clr = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data = 8'd0;
    bus1.out_ready = 1'b0;
    #13;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", bus1.in_ready, 1);

    run_tri(3, 4, 5, 0, 0, 0, 0);

    do_clr();
    run_tri(1, 1, 1, 0, 0, 0, 0);
    run_tri(255, 128, 128, 1, 0, 2, 1);
    run_tri(2, 4, 6, 0, 1, 0, 0);
    run_tri(0, 128, 127, 2, 0, 0, 2);
    run_tri(10, 100, 255, 0, 0, 1, 0);
    check("group_all", cnt_all1, 5);
    check("group_tri", cnt_tri1, 2);

    run_tri(1, 127, 255, 0, 0, 0, 5);
    run_tri(7, 7, 3, 0, 2, 1, 0);

    push(8'd5, 0);
    push(8'd5, 0);
    do_clr();
    run_tri(5, 5, 5, 0, 0, 0, 1);
    check("after_clr_all", cnt_all1, 1);

    push(8'd6, 0);
    push(8'd6, 1);
    push(8'd6, 0);
    check("pre_clr_hold", bus1.out_valid, 1);
    bus1.out_ready = 1'b1;
    do_clr();

    run_tri(3, 4, 5, 0, 0, 0, 0);
    run_tri(5, 5, 8, 1, 0, 0, 0);
    run_tri(9, 9, 9, 0, 0, 0, 2);
    run_tri(2, 3, 4, 0, 1, 0, 0);
    run_tri(200, 150, 100, 0, 0, 0, 0);
    check("sat_all", cnt_all2, 3);
    check("sat_tri", cnt_tri2, 3);

    for (int i = 0; i < 25; i++) begin
      if (i % 3 == 0) begin
        ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); rc = $urandom_range(0, 255);
      end else begin
        ra = $urandom_range(0, 12); rb = $urandom_range(0, 12); rc = $urandom_range(0, 12);
      end
      run_tri(ra, rb, rc, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_tri(10, 20, 25, 0, 0, 0, 0);

    push(8'd9, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_all = 0;
    m_tri = 0;
    check_zero_outputs("async_rst");
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", bus1.in_ready, 1);
    run_tri(4, 4, 4, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
